// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC interpolator chain (upsampler, integrators, combs).
package cic_pkg;

  localparam int unsigned SAMPLE_W   = 32;
  localparam int unsigned CIC_R      = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Pointer width that stays legal for a single-entry store.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; rst clears pointers and level.
module sample_fifo
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/zero_stuff_upsampler.sv
// CIC rate expander: one buffered sample on phase 0, zeros on the other R-1 phases.
// Define ZOH_HOLD_EN to repeat the last phase-0 value instead of zero-stuffing.
module zero_stuff_upsampler
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned R     = CIC_R,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic signed [WIDTH-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clr_underrun,
  output logic signed [WIDTH-1:0]  d_out,
  output logic                     out_stb,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned CNT_W = $clog2(R);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] d_out_q, d_out_d;
  logic                    out_stb_q, out_stb_d;
  logic                    underrun_q, underrun_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             phase0, last_phase, underrun_evt;

  assign in_ready     = !fifo_full;
  assign fifo_push    = in_valid && in_ready;
  assign phase0       = (cnt_q == '0);
  assign last_phase   = (cnt_q == CNT_W'(R - 1));
  assign fifo_pop     = run && phase0 && !fifo_empty;
  assign underrun_evt = run && phase0 && fifo_empty;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    cnt_d      = cnt_q;
    d_out_d    = d_out_q;
    out_stb_d  = 1'b0;
    underrun_d = underrun_q;

    if (!run) begin
      cnt_d   = '0;
      d_out_d = '0;
    end else begin
      cnt_d = last_phase ? '0 : cnt_q + CNT_W'(1);
      if (phase0) begin
        out_stb_d = 1'b1;
        d_out_d   = fifo_empty ? '0 : fifo_rdata;
      end else begin
`ifdef ZOH_HOLD_EN
        d_out_d = d_out_q;
`else
        d_out_d = '0;
`endif
      end
    end

    // A new underrun outranks a clear landing on the same edge.
    if (underrun_evt) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      d_out_q    <= '0;
      out_stb_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      d_out_q    <= d_out_d;
      out_stb_q  <= out_stb_d;
      underrun_q <= underrun_d;
    end
  end

  assign d_out    = d_out_q;
  assign out_stb  = out_stb_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_zero_stuff_upsampler.sv
// Directed bench for zero_stuff_upsampler with a queue-based reference model.
module tb_zero_stuff_upsampler;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned R     = 8;
  localparam int unsigned DEPTH = 2;
`ifdef ZOH_HOLD_EN
  localparam bit ZOH = 1'b1;
`else
  localparam bit ZOH = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst, run, in_valid, clr_underrun;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_ready, out_stb, underrun;
  logic signed [WIDTH-1:0] d_out;
  logic [$clog2(DEPTH):0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zero_stuff_upsampler #(.WIDTH(WIDTH), .R(R), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .clr_underrun (clr_underrun),
    .d_out        (d_out),
    .out_stb      (out_stb),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  // Reference model: a sample queue, a phase number and the expected outputs.
  logic signed [WIDTH-1:0] mq[$];
  int                      m_phase = 0;
  longint                  m_d = 0;
  bit                      m_stb = 0, m_un = 0, m_known = 0;
  bit                      m_accept, m_evt;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_phase = 0;
      m_d     = 0;
      m_stb   = 0;
      m_un    = 0;
      m_known = 1;
    end else begin
      m_accept = in_valid && (mq.size() < DEPTH);
      m_evt    = 0;
      if (run) begin
        if (m_phase == 0) begin
          m_stb = 1;
          if (mq.size() > 0) m_d = mq.pop_front();
          else begin
            m_d   = 0;
            m_evt = 1;
          end
        end else begin
          m_stb = 0;
          if (!ZOH) m_d = 0;
        end
        m_phase = (m_phase + 1) % R;
      end else begin
        m_phase = 0;
        m_d     = 0;
        m_stb   = 0;
      end
      if (m_evt) m_un = 1;
      else if (clr_underrun) m_un = 0;
      if (m_accept) mq.push_back(in_data);
    end
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one edge, then compare every output against the model.
  task automatic cyc();
    @(posedge clk);
    #2;
    if (m_known) begin
      chk("m_d_out", d_out, m_d);
      chk("m_out_stb", out_stb, m_stb);
      chk("m_underrun", underrun, m_un);
      chk("m_level", fifo_level, mq.size());
      chk("m_in_ready", in_ready, (mq.size() < DEPTH));
    end
  endtask

  longint acc;
  int     expv;

  initial begin
    rst = 1; run = 0; in_valid = 0; in_data = 0; clr_underrun = 0;
    cyc(); cyc();
    chk("rst_d_out", d_out, 0);
    chk("rst_stb", out_stb, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", in_ready, 1);

    // Running with nothing buffered underruns on the very first edge.
    rst = 0; run = 1;
    cyc();
    chk("ur_stb", out_stb, 1);
    chk("ur_d_out", d_out, 0);
    chk("ur_flag", underrun, 1);
    clr_underrun = 1;
    cyc();
    clr_underrun = 0;
    chk("ur_clear", underrun, 0);

    // Clear coinciding with a new underrun: set wins.
    run = 0;
    cyc();
    run = 1; clr_underrun = 1;
    cyc();
    chk("ur_set_wins", underrun, 1);
    run = 0;
    cyc();
    clr_underrun = 0;
    chk("ur_clear_idle", underrun, 0);

    // Three samples, one per frame, pushed ahead of phase 0.
    in_valid = 1; in_data = 100;
    cyc();
    in_valid = 0; run = 1;
    for (int i = 0; i < 24; i++) begin
      in_valid = (i == 3) || (i == 11);
      in_data  = (i == 3) ? 7 : -5;
      cyc();
      if (ZOH) expv = (i < 8) ? 100 : (i < 16) ? 7 : -5;
      else     expv = (i == 0) ? 100 : (i == 8) ? 7 : (i == 16) ? -5 : 0;
      chk("seq_d_out", d_out, expv);
      chk("seq_stb", out_stb, (i % 8) == 0);
    end
    in_valid = 0; run = 0;
    cyc();

    // Fill past capacity while idle, then drain one to reopen the input.
    in_valid = 1; in_data = 11;
    cyc();
    in_data = 22;
    cyc();
    in_data = 33;
    cyc();
    chk("full_level", fifo_level, 2);
    chk("full_ready", in_ready, 0);
    run = 1;
    cyc();
    chk("pop_head", d_out, 11);
    chk("pop_ready", in_ready, 1);
    chk("pop_level", fifo_level, 1);
    cyc();
    in_valid = 0;
    chk("third_in", fifo_level, 2);

    // Reset mid-frame discards the buffered 22 and 33.
    cyc(); cyc(); cyc();
    chk("pre_rst_level", fifo_level, 2);
    rst = 1;
    cyc();
    chk("mid_rst_d_out", d_out, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", in_ready, 1);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("no_stale", (d_out == 22) || (d_out == 33), 0);
      if (i == 0) chk("post_rst_phase0", out_stb, 1);
    end

    // Integrator fed by the stream of constant 1: staircase or ramp.
    rst = 1; run = 0;
    cyc();
    rst = 0; in_valid = 1; in_data = 1;
    cyc(); cyc();
    run = 1; acc = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      acc += d_out;
      chk("integ", acc, ZOH ? (i + 1) : (i / 8 + 1));
    end
    in_valid = 0; run = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
